des_iter_core: RTL and testbench
================================

# des_iter_core

Parametrised, handshaked DES engine supporting both encryption and decryption. `ROUNDS_PER_CYCLE` Feistel rounds are unrolled per clock, so area and latency trade off from 16 cycles per block down to 1. Subkeys are generated on the fly by rotating C/D registers: forward for encrypt, backward for decrypt. The block sits between a 64-bit block source and sink with valid/ready on both sides, and succeeds the fixed 16-stage encrypt-only pipeline.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_data`, `in_key` and `in_decrypt` are valid.
- `in_ready` out 1: engine can accept a block.
- `in_data` in 64: plaintext (encrypt) or ciphertext (decrypt).
- `in_key` in 64: DES key; parity bits are ignored by PC1.
- `in_decrypt` in 1: 0 = encrypt, 1 = decrypt.
- `out_valid` out 1: `out_data` holds a finished result.
- `out_ready` in 1: sink accepts `out_data`.
- `out_data` out 64: result block.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - BUSY: runs rounds.
  - DONE: `out_valid`=1.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, round counter 0, L/R/C/D/mode registers 0.
- IDLE → BUSY when `in_valid` && `in_ready`. On that edge:
  - {L,R} ← IP(`in_data`).
  - {C,D} ← PC1(`in_key`).
  - mode ← `in_decrypt`.
  - round counter ← 0.
- BUSY: each edge applies rounds j = cnt+1 … cnt+`ROUNDS_PER_CYCLE` combinationally in sequence; cnt advances by `ROUNDS_PER_CYCLE`.
  - Round: L' = R; R' = L ^ f(R, subkey).
  - Encrypt round j: rotate C,D left by SHIFT(j), then subkey = PC2(C,D).
  - Decrypt round j: subkey = PC2(C,D) using the current C,D, then rotate C,D right by SHIFT(17−j). This yields K16…K1; C/D after round 16 equal PC1(key) again.
  - SHIFT(j) = 1 for j ∈ {1, 2, 9, 16}, otherwise 2.
- BUSY → DONE on the edge completing round 16. That edge registers `out_data` ← IP⁻¹({R16, L16}) (halves swapped).
- DONE → IDLE when `out_ready`. `out_data` holds its value until the next DONE load; it is not cleared.
- `out_data` stays stable while `out_valid`=1 and `out_ready`=0 (backpressure held indefinitely).
- `in_valid` is ignored outside IDLE. Inputs are sampled only on the accept edge, so later changes do not affect the block in flight.
- Asserting `RST_N` low in any state immediately forces reset values. The in-flight block is discarded and no `out_valid` is produced for it.

## Timing
- N = 16 / `ROUNDS_PER_CYCLE`.
- Accept on edge t0 → `out_valid` high after edge tN (latency N cycles).
- Earliest next accept is edge tN+2, giving a throughput of one block per N+2 cycles with `out_ready` held high.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- Critical path is `ROUNDS_PER_CYCLE` chained f-functions plus the key rotate/PC2 logic.

## Structure
- Shared package `des_pkg` holds:
  - permutation tables IP, IP_INV, E, P, PC1, PC2;
  - S-box tables S1–S8 as constants/functions;
  - SHIFT schedule constant;
  - FSM state enum (IDLE, BUSY, DONE).
- Sub-module `des_round`: one combinational Feistel round, {L,R} + C/D + round index + mode → {L',R'} + next C/D.
  - Instantiated `ROUNDS_PER_CYCLE` times in a generate chain.
  - Reuses the existing f/S-box logic.
- Top level: FSM, round counter (5 bits), L/R/C/D/mode registers, output register.

## Test plan
- Encrypt, `ROUNDS_PER_CYCLE`=1: key 133457799BBCDFF1, data 0123456789ABCDEF → `out_data` 85E813540F0AB405; `out_valid` rises exactly 16 cycles after accept.
- Decrypt, same key: data 85E813540F0AB405 → 0123456789ABCDEF.
- Encrypt, `ROUNDS_PER_CYCLE`=16 and =4: key 0E329232EA6D0D73, data 8787878787878787 → 0000000000000000, with latency 1 and 4 cycles respectively.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_data` stable, `in_ready`=0, a new `in_valid` is not accepted; release → IDLE next cycle, then accept.
- Back-to-back: `in_valid` held high with 3 blocks, `out_ready`=1 → 3 correct results, accepts spaced N+2 cycles apart, `in_data` changing mid-BUSY has no effect.
- Reset mid-BUSY (cycle 7 of 16) → `out_valid`=0, `in_ready`=1, `out_data`=0 immediately; the next block encrypts correctly.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared DES constants and helpers.
//   - FSM state enum for the iterative engine
//   - permutation tables IP, IP_INV, E, P, PC1, PC2 (1-based, MSB = bit 1)
//   - S-boxes S1..S8 packed as 64 nibbles each, index = row*16 + col
//   - key rotation schedule and rotate helpers
//   - Feistel f-function built from the tables above
package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } des_state_e;

  // Bit (j-1) set means round j rotates by one place, otherwise by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  localparam logic [6:0] IP_TAB [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

  localparam logic [6:0] IP_INV_TAB [64] = '{
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25};

  localparam logic [6:0] E_TAB [48] = '{
    7'd32, 7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd4,  7'd5,
    7'd6,  7'd7,  7'd8,  7'd9,  7'd8,  7'd9,  7'd10, 7'd11,
    7'd12, 7'd13, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17,
    7'd16, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd20, 7'd21,
    7'd22, 7'd23, 7'd24, 7'd25, 7'd24, 7'd25, 7'd26, 7'd27,
    7'd28, 7'd29, 7'd28, 7'd29, 7'd30, 7'd31, 7'd32, 7'd1};

  localparam logic [6:0] P_TAB [32] = '{
    7'd16, 7'd7,  7'd20, 7'd21, 7'd29, 7'd12, 7'd28, 7'd17,
    7'd1,  7'd15, 7'd23, 7'd26, 7'd5,  7'd18, 7'd31, 7'd10,
    7'd2,  7'd8,  7'd24, 7'd14, 7'd32, 7'd27, 7'd3,  7'd9,
    7'd19, 7'd13, 7'd30, 7'd6,  7'd22, 7'd11, 7'd4,  7'd25};

  localparam logic [6:0] PC1_TAB [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

  localparam logic [6:0] PC2_TAB [48] = '{
    7'd14, 7'd17, 7'd11, 7'd24, 7'd1,  7'd5,  7'd3,  7'd28,
    7'd15, 7'd6,  7'd21, 7'd10, 7'd23, 7'd19, 7'd12, 7'd4,
    7'd26, 7'd8,  7'd16, 7'd7,  7'd27, 7'd20, 7'd13, 7'd2,
    7'd41, 7'd52, 7'd31, 7'd37, 7'd47, 7'd55, 7'd30, 7'd40,
    7'd51, 7'd45, 7'd33, 7'd48, 7'd44, 7'd49, 7'd39, 7'd56,
    7'd34, 7'd53, 7'd46, 7'd42, 7'd50, 7'd36, 7'd29, 7'd32};

  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip(input logic [63:0] d);
    logic [63:0] r;
    r = 64'd0;
    for (int unsigned i = 32'd0; i < 32'd64; i++) r[32'd63 - i] = d[32'd64 - 32'(IP_TAB[i])];
    return r;
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] d);
    logic [63:0] r;
    r = 64'd0;
    for (int unsigned i = 32'd0; i < 32'd64; i++) r[32'd63 - i] = d[32'd64 - 32'(IP_INV_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] d);
    logic [47:0] r;
    r = 48'd0;
    for (int unsigned i = 32'd0; i < 32'd48; i++) r[32'd47 - i] = d[32'd32 - 32'(E_TAB[i])];
    return r;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0] r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) r[32'd31 - i] = d[32'd32 - 32'(P_TAB[i])];
    return r;
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] d);
    logic [55:0] r;
    r = 56'd0;
    for (int unsigned i = 32'd0; i < 32'd56; i++) r[32'd55 - i] = d[32'd64 - 32'(PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] d);
    logic [47:0] r;
    r = 48'd0;
    for (int unsigned i = 32'd0; i < 32'd48; i++) r[32'd47 - i] = d[32'd56 - 32'(PC2_TAB[i])];
    return r;
  endfunction

  // Outer bits select the row, inner four bits the column.
  function automatic logic [3:0] sbox(input int unsigned n, input logic [5:0] x);
    int unsigned pos;
    pos = 32'({x[5], x[0]}) * 32'd16 + 32'(x[4:1]);
    return SBOX[n][32'd255 - pos * 32'd4 -: 4];
  endfunction

  function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = e_expand(r) ^ k;
    s = 32'd0;
    for (int unsigned b = 32'd0; b < 32'd8; b++) s[32'd31 - b * 32'd4 -: 4] = sbox(b, x[32'd47 - b * 32'd6 -: 6]);
    return p_perm(s);
  endfunction

  // Out-of-range indices wrap harmlessly; they only occur outside BUSY.
  function automatic logic shift_is_two(input logic [4:0] j);
    return ~SHIFT_ONE[4'(j - 5'd1)];
  endfunction

  function automatic logic [27:0] rot_l(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rot_r(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES round including on-the-fly subkey.
//   l, r            : current Feistel halves
//   c, d            : current key halves
//   round_idx       : round number j (1..16)
//   decrypt         : 0 = rotate-then-use (K1..K16), 1 = use-then-rotate back (K16..K1)
//   l_next, r_next  : halves after the round
//   c_next, d_next  : key halves handed to the next round
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic [4:0]  round_idx,
  input  logic        decrypt,
  output logic [31:0] l_next,
  output logic [31:0] r_next,
  output logic [27:0] c_next,
  output logic [27:0] d_next
);

  logic        two_s;
  logic [27:0] c_key_s;
  logic [27:0] d_key_s;
  logic [47:0] subkey_s;

  // Select subkey source halves and the halves passed on, per direction.
  always_comb begin
    two_s   = 1'b0;
    c_key_s = c;
    d_key_s = d;
    c_next  = c;
    d_next  = d;
    if (decrypt) begin
      // Decrypt walks the schedule backwards, so round j undoes shift 17-j.
      two_s   = shift_is_two(5'd17 - round_idx);
      c_key_s = c;
      d_key_s = d;
      c_next  = rot_r(c, two_s);
      d_next  = rot_r(d, two_s);
    end else begin
      two_s   = shift_is_two(round_idx);
      c_key_s = rot_l(c, two_s);
      d_key_s = rot_l(d, two_s);
      c_next  = c_key_s;
      d_next  = d_key_s;
    end
  end

  assign subkey_s = pc2({c_key_s, d_key_s});
  assign l_next   = r;
  assign r_next   = l ^ feistel_f(r, subkey_s);

endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES encrypt/decrypt engine, ROUNDS_PER_CYCLE
// rounds per clock (1, 2, 4, 8 or 16), latency 16/ROUNDS_PER_CYCLE cycles.
//   CLK, RST_N                   : clock, async active-low reset
//   in_valid/in_ready            : input handshake (accepted only in IDLE)
//   in_data, in_key, in_decrypt  : block, key and direction, sampled on accept
//   out_valid/out_ready          : output handshake (result held until taken)
//   out_data                     : registered result block
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);

  localparam int       RPC   = ROUNDS_PER_CYCLE;
  localparam logic [4:0] RPC_W = 5'(ROUNDS_PER_CYCLE);

  if (!(RPC == 32'sd1 || RPC == 32'sd2 || RPC == 32'sd4 || RPC == 32'sd8 || RPC == 32'sd16)) begin : g_bad_rpc
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  des_state_e  state_r;
  des_state_e  state_s;
  logic [4:0]  cnt_r;
  logic [31:0] l_r;
  logic [31:0] r_r;
  logic [27:0] c_r;
  logic [27:0] d_r;
  logic        mode_r;
  logic [63:0] out_data_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        last_s;

  logic [31:0] l_s [0:RPC];
  logic [31:0] r_s [0:RPC];
  logic [27:0] c_s [0:RPC];
  logic [27:0] d_s [0:RPC];

  assign l_s[0] = l_r;
  assign r_s[0] = r_r;
  assign c_s[0] = c_r;
  assign d_s[0] = d_r;

  for (genvar k = 0; k < RPC; k++) begin : g_round
    des_round u_round (
      .l         (l_s[k]),
      .r         (r_s[k]),
      .c         (c_s[k]),
      .d         (d_s[k]),
      .round_idx (cnt_r + 5'(k) + 5'd1),
      .decrypt   (mode_r),
      .l_next    (l_s[k+1]),
      .r_next    (r_s[k+1]),
      .c_next    (c_s[k+1]),
      .d_next    (d_s[k+1])
    );
  end

  assign last_s = ((cnt_r + RPC_W) == 5'd16);

  // Next-state decode for the IDLE/BUSY/DONE handshake FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)  state_s = BUSY; else state_s = IDLE;
      BUSY:    if (last_s)    state_s = DONE; else state_s = BUSY;
      DONE:    if (out_ready) state_s = IDLE; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus flopped handshake outputs decoded from next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: load on accept, advance RPC rounds per BUSY cycle, capture result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r      <= 5'd0;
      l_r        <= 32'd0;
      r_r        <= 32'd0;
      c_r        <= 28'd0;
      d_r        <= 28'd0;
      mode_r     <= 1'b0;
      out_data_r <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            {l_r, r_r} <= ip(in_data);
            {c_r, d_r} <= pc1(in_key);
            mode_r     <= in_decrypt;
            cnt_r      <= 5'd0;
          end
        end
        BUSY: begin
          l_r   <= l_s[RPC];
          r_r   <= r_s[RPC];
          c_r   <= c_s[RPC];
          d_r   <= d_s[RPC];
          cnt_r <= cnt_r + RPC_W;
          // Final swap: preoutput is {R16, L16}.
          if (last_s) out_data_r <= ip_inv({r_s[RPC], l_s[RPC]});
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: directed, scoreboarded bench for des_iter_core with
// ROUNDS_PER_CYCLE = 1, 4 and 16 instances sharing clock, reset and data.
module tb_des_iter_core;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  logic        CLK;
  logic        RST_N;
  logic [63:0] in_data;
  logic [63:0] in_key;
  logic        in_decrypt;
  logic        out_ready;
  logic        in_valid1, in_valid4, in_valid16;
  logic        in_ready1, in_ready4, in_ready16;
  logic        out_valid1, out_valid4, out_valid16;
  logic [63:0] out_data1, out_data4, out_data16;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_v;
  int          cyc;
  int          acc_cnt;
  int          out_cnt;
  int          acc_cyc [3];
  logic        prev_ready;
  logic [63:0] b_data [3];
  logic [63:0] b_key [3];
  logic        b_dec [3];
  logic [63:0] b_exp [3];

  des_iter_core #(.ROUNDS_PER_CYCLE(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));

  des_iter_core #(.ROUNDS_PER_CYCLE(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4));

  des_iter_core #(.ROUNDS_PER_CYCLE(16)) dut16 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic rdy(input int w);
    case (w)
      1:       return in_ready1;
      4:       return in_ready4;
      default: return in_ready16;
    endcase
  endfunction

  function automatic logic vld(input int w);
    case (w)
      1:       return out_valid1;
      4:       return out_valid4;
      default: return out_valid16;
    endcase
  endfunction

  function automatic logic [63:0] dat(input int w);
    case (w)
      1:       return out_data1;
      4:       return out_data4;
      default: return out_data16;
    endcase
  endfunction

  task automatic set_valid(input int w, input logic v);
    case (w)
      1:       in_valid1 = v;
      4:       in_valid4 = v;
      default: in_valid16 = v;
    endcase
  endtask

  // One block through DUT w with out_ready high; called at a negedge.
  task automatic run_block(input int w, input logic [63:0] data, input logic [63:0] key,
                           input logic dec, input logic [63:0] expv, input int lat, input string tag);
    int n;
    logic [63:0] e;
    chk({tag, "_ready_idle"}, 64'(rdy(w)), 64'd1);
    in_data = data; in_key = key; in_decrypt = dec;
    set_valid(w, 1'b1);
    exp_q.push_back(expv);
    @(posedge CLK); @(negedge CLK);
    set_valid(w, 1'b0);
    in_data = ~data; in_key = ~key; in_decrypt = ~dec;
    chk({tag, "_ready_busy"}, 64'(rdy(w)), 64'd0);
    n = 0;
    while (!vld(w) && n < 40) begin
      @(posedge CLK); n++; @(negedge CLK);
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_valid"}, 64'(vld(w)), 64'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'bx;
    chk({tag, "_data"}, dat(w), e);
    @(posedge CLK); @(negedge CLK);
    chk({tag, "_valid_drop"}, 64'(vld(w)), 64'd0);
    chk({tag, "_ready_back"}, 64'(rdy(w)), 64'd1);
  endtask

  initial begin
    RST_N = 1'b0;
    in_valid1 = 1'b0; in_valid4 = 1'b0; in_valid16 = 1'b0;
    in_data = 64'd0; in_key = 64'd0; in_decrypt = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_out_data", out_data1, 64'd0);
    chk("rst_in_ready16", 64'(in_ready16), 64'd1);
    chk("rst_out_valid4", 64'(out_valid4), 64'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    run_block(1, P1, K1, 1'b0, C1, 16, "enc_r1");
    run_block(1, C1, K1, 1'b1, P1, 16, "dec_r1");
    run_block(16, P2, K2, 1'b0, C2, 1, "enc_r16");
    run_block(4, P2, K2, 1'b0, C2, 4, "enc_r4");
    run_block(4, C1, K1, 1'b1, P1, 4, "dec_r4");
    run_block(16, C2, K2, 1'b1, P2, 1, "dec_r16");

    // Backpressure: hold the result for 10 cycles while a new block waits.
    out_ready = 1'b0;
    in_data = P1; in_key = K1; in_decrypt = 1'b0; in_valid1 = 1'b1;
    exp_q.push_back(C1);
    @(posedge CLK); @(negedge CLK);
    in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 40) begin
      @(posedge CLK); cyc++; @(negedge CLK);
    end
    chk("bp_latency", 64'(cyc), 64'd16);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'bx;
    chk("bp_data", out_data1, exp_v);
    in_valid1 = 1'b1; in_data = C1; in_decrypt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); @(negedge CLK);
      chk("bp_hold_valid", 64'(out_valid1), 64'd1);
      chk("bp_hold_ready", 64'(in_ready1), 64'd0);
      chk("bp_hold_data", out_data1, C1);
    end
    out_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    chk("bp_release_valid", 64'(out_valid1), 64'd0);
    chk("bp_release_ready", 64'(in_ready1), 64'd1);
    exp_q.push_back(P1);
    @(posedge CLK); @(negedge CLK);
    chk("bp_accept", 64'(in_ready1), 64'd0);
    in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 40) begin
      @(posedge CLK); cyc++; @(negedge CLK);
    end
    chk("bp2_latency", 64'(cyc), 64'd16);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'bx;
    chk("bp2_data", out_data1, exp_v);
    @(posedge CLK); @(negedge CLK);

    // Back-to-back: in_valid held high, data scrambled while busy.
    b_data[0] = P1; b_key[0] = K1; b_dec[0] = 1'b0; b_exp[0] = C1;
    b_data[1] = C2; b_key[1] = K2; b_dec[1] = 1'b1; b_exp[1] = P2;
    b_data[2] = C1; b_key[2] = K1; b_dec[2] = 1'b1; b_exp[2] = P1;
    in_data = b_data[0]; in_key = b_key[0]; in_decrypt = b_dec[0]; in_valid1 = 1'b1;
    prev_ready = in_ready1;
    cyc = 0; acc_cnt = 0; out_cnt = 0;
    while (out_cnt < 3 && cyc < 200) begin
      @(posedge CLK); cyc++; @(negedge CLK);
      if (prev_ready && in_valid1 && acc_cnt < 3) begin
        acc_cyc[acc_cnt] = cyc;
        exp_q.push_back(b_exp[acc_cnt]);
        acc_cnt++;
        in_data = {$urandom, $urandom}; in_key = {$urandom, $urandom};
        in_decrypt = 1'($urandom_range(1, 0));
        if (acc_cnt == 3) in_valid1 = 1'b0;
      end
      if (out_valid1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 64'bx;
        chk("b2b_data", out_data1, exp_v);
        out_cnt++;
        if (acc_cnt < 3) begin
          in_data = b_data[acc_cnt]; in_key = b_key[acc_cnt]; in_decrypt = b_dec[acc_cnt];
        end
      end
      prev_ready = in_ready1;
    end
    chk("b2b_accepts", 64'(acc_cnt), 64'd3);
    chk("b2b_outputs", 64'(out_cnt), 64'd3);
    chk("b2b_spacing_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd18);
    chk("b2b_spacing_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd18);
    @(posedge CLK); @(negedge CLK);

    // Reset in cycle 7 of 16; the aborted block must never appear.
    in_data = P2; in_key = K2; in_decrypt = 1'b0; in_valid1 = 1'b1;
    @(posedge CLK); @(negedge CLK);
    in_valid1 = 1'b0;
    repeat (7) @(negedge CLK);
    chk("mid_busy_ready", 64'(in_ready1), 64'd0);
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid1), 64'd0);
    chk("async_rst_ready", 64'(in_ready1), 64'd1);
    chk("async_rst_data", out_data1, 64'd0);
    chk("async_rst_data4", out_data4, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("no_ghost_valid", 64'(out_valid1), 64'd0);
    run_block(1, P1, K1, 1'b0, C1, 16, "enc_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
